// File: rtl/exe_issue_sched.sv
// exe_issue_sched: collapsing, age-ordered issue queue feeding one ALU and one
// BRU execute port. Slot 0 holds the oldest micro-op; valid entries are always
// packed from slot 0 upward, so "oldest ready" is simply the lowest ready index.
// Optional feature macro: EXE_WAKEUP_BYPASS_EN -- when defined, a same-cycle
// result broadcast also counts as ready for select on stored entries.

package uopc;
  typedef enum logic [4:0] {
    UOP_LUI, UOP_AUIPC, UOP_JAL, UOP_JALR,
    UOP_BEQ, UOP_BNE, UOP_BLT, UOP_BGE, UOP_BLTU, UOP_BGEU,
    UOP_ADDI, UOP_SLTI, UOP_SLTIU, UOP_XORI, UOP_ORI, UOP_ANDI,
    UOP_SLLI, UOP_SRLI, UOP_SRAI,
    UOP_ADD, UOP_SUB, UOP_SLL, UOP_SLT, UOP_SLTU, UOP_XOR,
    UOP_SRL, UOP_SRA, UOP_OR, UOP_AND
  } micro_opcode_t;
endpackage

package immt;
  typedef enum logic [2:0] {IMM_I, IMM_S, IMM_B, IMM_U, IMM_J} imm_type_t;
endpackage

module exe_issue_sched #(
  parameter int DEPTH = 8,
  parameter int TAG_W = 6,
  parameter int ROB_W = 5
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      flush,
  input  logic                      disp_valid,
  output logic                      disp_ready,
  input  uopc::micro_opcode_t       disp_uopcode,
  input  logic [19:0]               disp_imm,
  input  immt::imm_type_t           disp_imm_type,
  input  logic [TAG_W-1:0]          disp_rs1,
  input  logic [TAG_W-1:0]          disp_rs2,
  input  logic                      disp_rs1_rdy,
  input  logic                      disp_rs2_rdy,
  input  logic [TAG_W-1:0]          disp_rd,
  input  logic [ROB_W-1:0]          disp_rob,
  input  logic                      wk_valid,
  input  logic [TAG_W-1:0]          wk_tag,
  output logic                      alu_valid,
  input  logic                      alu_ready,
  output uopc::micro_opcode_t       alu_uopcode,
  output logic [19:0]               alu_imm,
  output immt::imm_type_t           alu_imm_type,
  output logic [TAG_W-1:0]          alu_rs1,
  output logic [TAG_W-1:0]          alu_rs2,
  output logic [TAG_W-1:0]          alu_rd,
  output logic [ROB_W-1:0]          alu_rob,
  output logic                      bru_valid,
  input  logic                      bru_ready,
  output uopc::micro_opcode_t       bru_uopcode,
  output logic [19:0]               bru_imm,
  output immt::imm_type_t           bru_imm_type,
  output logic [TAG_W-1:0]          bru_rs1,
  output logic [TAG_W-1:0]          bru_rs2,
  output logic [TAG_W-1:0]          bru_rd,
  output logic [ROB_W-1:0]          bru_rob,
  output logic [$clog2(DEPTH):0]    occupancy
);

  localparam int IDX_W = $clog2(DEPTH);
  localparam int OCC_W = IDX_W + 1;
  localparam logic [OCC_W-1:0] FULL = OCC_W'(DEPTH);

  typedef struct packed {
    uopc::micro_opcode_t uopcode;
    logic [19:0]         imm;
    immt::imm_type_t     imm_type;
    logic [TAG_W-1:0]    rs1;
    logic [TAG_W-1:0]    rs2;
    logic [TAG_W-1:0]    rd;
    logic [ROB_W-1:0]    rob;
  } uop_t;

  function automatic logic is_bru(uopc::micro_opcode_t op);
    case (op)
      uopc::UOP_AUIPC, uopc::UOP_JAL, uopc::UOP_JALR,
      uopc::UOP_BEQ, uopc::UOP_BNE, uopc::UOP_BLT,
      uopc::UOP_BGE, uopc::UOP_BLTU, uopc::UOP_BGEU: is_bru = 1'b1;
      default:                                       is_bru = 1'b0;
    endcase
  endfunction

  uop_t             q  [DEPTH];
  uop_t             nq [DEPTH];
  logic [DEPTH-1:0] r1, r2, nr1, nr2;
  logic [DEPTH-1:0] vld, bru_c, wk1, wk2, rdy;
  logic [OCC_W-1:0] occ_q, occ_d, fire_cnt, survivors;
  logic [IDX_W-1:0] alu_idx, bru_idx;
  logic             alu_hit, bru_hit, fire_alu, fire_bru, accept;
  logic             disp_r1, disp_r2;
  uop_t             disp_uop, alu_uop, bru_uop;

  // Per-entry status: validity, port class, broadcast match and select-readiness.
  always_comb begin
    vld   = '0;
    bru_c = '0;
    wk1   = '0;
    wk2   = '0;
    rdy   = '0;
    for (int i = 0; i < DEPTH; i++) begin
      vld[i]   = OCC_W'(i) < occ_q;
      bru_c[i] = is_bru(q[i].uopcode);
      wk1[i]   = wk_valid && (q[i].rs1 == wk_tag);
      wk2[i]   = wk_valid && (q[i].rs2 == wk_tag);
`ifdef EXE_WAKEUP_BYPASS_EN
      rdy[i]   = vld[i] && (r1[i] || wk1[i]) && (r2[i] || wk2[i]);
`else
      rdy[i]   = vld[i] && r1[i] && r2[i];
`endif
    end
  end

  // Oldest-ready select per port and the issue handshakes.
  always_comb begin
    alu_hit = 1'b0;
    bru_hit = 1'b0;
    alu_idx = '0;
    bru_idx = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (rdy[i]) begin
        if (bru_c[i]) begin
          if (!bru_hit) begin
            bru_hit = 1'b1;
            bru_idx = IDX_W'(i);
          end
        end else if (!alu_hit) begin
          alu_hit = 1'b1;
          alu_idx = IDX_W'(i);
        end
      end
    end
    alu_uop    = q[alu_idx];
    bru_uop    = q[bru_idx];
    alu_valid  = rst && !flush && alu_hit;
    bru_valid  = rst && !flush && bru_hit;
    fire_alu   = alu_valid && alu_ready;
    fire_bru   = bru_valid && bru_ready;
    disp_ready = rst && !flush && (occ_q < FULL);
    accept     = disp_valid && disp_ready;
  end

  // Collapse out fired entries, apply wakeup to survivors, append the new uop.
  always_comb begin
    int lo;
    int hi;
    int ai;
    int bi;
    ai        = int'(alu_idx);
    bi        = int'(bru_idx);
    lo        = DEPTH + 2;
    hi        = DEPTH + 2;
    if (fire_alu && fire_bru) begin
      lo = (ai < bi) ? ai : bi;
      hi = (ai < bi) ? bi : ai;
    end else if (fire_alu) begin
      lo = ai;
    end else if (fire_bru) begin
      lo = bi;
    end
    fire_cnt  = OCC_W'(fire_alu) + OCC_W'(fire_bru);
    survivors = occ_q - fire_cnt;
    occ_d     = survivors + OCC_W'(accept);

    disp_uop.uopcode  = disp_uopcode;
    disp_uop.imm      = disp_imm;
    disp_uop.imm_type = disp_imm_type;
    disp_uop.rs1      = disp_rs1;
    disp_uop.rs2      = disp_rs2;
    disp_uop.rd       = disp_rd;
    disp_uop.rob      = disp_rob;
    // Tag 0 is the hardwired-zero register and never waits on a producer.
    disp_r1 = disp_rs1_rdy || (disp_rs1 == '0) || (wk_valid && disp_rs1 == wk_tag);
    disp_r2 = disp_rs2_rdy || (disp_rs2 == '0) || (wk_valid && disp_rs2 == wk_tag);

    nr1 = '0;
    nr2 = '0;
    for (int j = 0; j < DEPTH; j++) begin
      int               src;
      logic [IDX_W-1:0] si;
      // j-th survivor skips over the (at most two) removed slots lo < hi.
      src    = (j < lo) ? j : ((j + 1 < hi) ? j + 1 : j + 2);
      si     = IDX_W'(src);
      nq[j]  = q[si];
      nr1[j] = r1[si] || wk1[si];
      nr2[j] = r2[si] || wk2[si];
      if (accept && (OCC_W'(j) == survivors)) begin
        nq[j]  = disp_uop;
        nr1[j] = disp_r1;
        nr2[j] = disp_r2;
      end
    end
  end

  // Occupancy and ready bits; reset and flush both empty the queue.
  always_ff @(posedge clk) begin
    if (!rst || flush) begin
      occ_q <= '0;
      r1    <= '0;
      r2    <= '0;
    end else begin
      occ_q <= occ_d;
      r1    <= nr1;
      r2    <= nr2;
    end
  end

  // Payload storage; contents beyond occupancy are don't-care.
  always_ff @(posedge clk) begin
    if (rst && !flush) begin
      for (int j = 0; j < DEPTH; j++) q[j] <= nq[j];
    end
  end

  assign occupancy    = occ_q;
  assign alu_uopcode  = alu_uop.uopcode;
  assign alu_imm      = alu_uop.imm;
  assign alu_imm_type = alu_uop.imm_type;
  assign alu_rs1      = alu_uop.rs1;
  assign alu_rs2      = alu_uop.rs2;
  assign alu_rd       = alu_uop.rd;
  assign alu_rob      = alu_uop.rob;
  assign bru_uopcode  = bru_uop.uopcode;
  assign bru_imm      = bru_uop.imm;
  assign bru_imm_type = bru_uop.imm_type;
  assign bru_rs1      = bru_uop.rs1;
  assign bru_rs2      = bru_uop.rs2;
  assign bru_rd       = bru_uop.rd;
  assign bru_rob      = bru_uop.rob;

  // Fires can never exceed the number of stored entries.
  a_no_underflow: assert property (@(posedge clk) disable iff (!rst) (fire_cnt <= occ_q));

endmodule

// File: tb/tb_exe_issue_sched.sv
// Testbench for exe_issue_sched: per-cycle expected responses from a queue-based
// reference model are pushed to a scoreboard and compared by a separate monitor.
`timescale 1ns/1ps
module tb_exe_issue_sched;
  import uopc::*;
  import immt::*;

  localparam int DEPTH = 8;
  localparam int TAG_W = 6;
  localparam int ROB_W = 5;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst, flush, disp_valid, disp_ready;
  micro_opcode_t disp_uopcode, alu_uopcode, bru_uopcode;
  logic [19:0] disp_imm, alu_imm, bru_imm;
  imm_type_t disp_imm_type, alu_imm_type, bru_imm_type;
  logic [TAG_W-1:0] disp_rs1, disp_rs2, disp_rd, wk_tag;
  logic [TAG_W-1:0] alu_rs1, alu_rs2, alu_rd, bru_rs1, bru_rs2, bru_rd;
  logic disp_rs1_rdy, disp_rs2_rdy, wk_valid;
  logic [ROB_W-1:0] disp_rob, alu_rob, bru_rob;
  logic alu_valid, alu_ready, bru_valid, bru_ready;
  logic [$clog2(DEPTH):0] occupancy;

  exe_issue_sched #(.DEPTH(DEPTH), .TAG_W(TAG_W), .ROB_W(ROB_W)) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .disp_valid(disp_valid), .disp_ready(disp_ready),
    .disp_uopcode(disp_uopcode), .disp_imm(disp_imm), .disp_imm_type(disp_imm_type),
    .disp_rs1(disp_rs1), .disp_rs2(disp_rs2),
    .disp_rs1_rdy(disp_rs1_rdy), .disp_rs2_rdy(disp_rs2_rdy),
    .disp_rd(disp_rd), .disp_rob(disp_rob),
    .wk_valid(wk_valid), .wk_tag(wk_tag),
    .alu_valid(alu_valid), .alu_ready(alu_ready),
    .alu_uopcode(alu_uopcode), .alu_imm(alu_imm), .alu_imm_type(alu_imm_type),
    .alu_rs1(alu_rs1), .alu_rs2(alu_rs2), .alu_rd(alu_rd), .alu_rob(alu_rob),
    .bru_valid(bru_valid), .bru_ready(bru_ready),
    .bru_uopcode(bru_uopcode), .bru_imm(bru_imm), .bru_imm_type(bru_imm_type),
    .bru_rs1(bru_rs1), .bru_rs2(bru_rs2), .bru_rd(bru_rd), .bru_rob(bru_rob),
    .occupancy(occupancy)
  );

  typedef struct packed {
    logic [4:0]       op;
    logic [19:0]      imm;
    logic [2:0]       it;
    logic [TAG_W-1:0] rs1;
    logic [TAG_W-1:0] rs2;
    logic [TAG_W-1:0] rd;
    logic [ROB_W-1:0] rob;
  } pl_t;

  typedef struct { pl_t p; bit r1; bit r2; } ent_t;
  typedef struct { bit av; pl_t ap; bit bv; pl_t bp; bit dr; int occ; } exp_t;

  ent_t mq[$];
  exp_t expq[$];
  int   checks = 0;
  int   errors = 0;
  bit   run = 1'b0;

  function automatic bit m_bru(logic [4:0] op);
    return op inside {UOP_AUIPC, UOP_JAL, UOP_JALR, UOP_BEQ, UOP_BNE,
                      UOP_BLT, UOP_BGE, UOP_BLTU, UOP_BGEU};
  endfunction

  function automatic bit sel_ready(ent_t e);
    bit a, b;
    a = e.r1;
    b = e.r2;
`ifdef EXE_WAKEUP_BYPASS_EN
    a = a || (wk_valid && e.p.rs1 == wk_tag);
    b = b || (wk_valid && e.p.rs2 == wk_tag);
`endif
    return a && b;
  endfunction

  function automatic pl_t cur_disp();
    return {disp_uopcode, disp_imm, disp_imm_type, disp_rs1, disp_rs2, disp_rd, disp_rob};
  endfunction

  // Reference model: evaluate this cycle's expected outputs, then advance to the edge.
  task automatic model_step();
    exp_t e;
    int   ai, bi;
    bit   fa, fb;
    ai = -1;
    bi = -1;
    e.occ = mq.size();
    e.dr  = rst && !flush && (mq.size() < DEPTH);
    foreach (mq[i]) begin
      if (sel_ready(mq[i])) begin
        if (m_bru(mq[i].p.op)) begin if (bi < 0) bi = i; end
        else if (ai < 0) ai = i;
      end
    end
    e.av = rst && !flush && (ai >= 0);
    e.bv = rst && !flush && (bi >= 0);
    e.ap = (ai >= 0) ? mq[ai].p : '0;
    e.bp = (bi >= 0) ? mq[bi].p : '0;
    expq.push_back(e);
    fa = e.av && alu_ready;
    fb = e.bv && bru_ready;
    if (!rst || flush) begin
      mq.delete();
    end else begin
      if (fa && fb) begin
        if (ai > bi) begin mq.delete(ai); mq.delete(bi); end
        else begin mq.delete(bi); mq.delete(ai); end
      end else if (fa) mq.delete(ai);
      else if (fb) mq.delete(bi);
      foreach (mq[i]) begin
        ent_t t;
        t = mq[i];
        if (wk_valid && t.p.rs1 == wk_tag) t.r1 = 1'b1;
        if (wk_valid && t.p.rs2 == wk_tag) t.r2 = 1'b1;
        mq[i] = t;
      end
      if (disp_valid && e.dr) begin
        ent_t n;
        n.p  = cur_disp();
        n.r1 = disp_rs1_rdy || (disp_rs1 == 0) || (wk_valid && disp_rs1 == wk_tag);
        n.r2 = disp_rs2_rdy || (disp_rs2 == 0) || (wk_valid && disp_rs2 == wk_tag);
        mq.push_back(n);
      end
    end
  endtask

  task automatic chk(string name, logic [63:0] act, logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, req, $time);
    end
  endtask

  initial forever begin
    @(negedge clk);
    if (run) model_step();
  end

  // Monitor: pops one expected record per cycle and compares what the DUT presents.
  initial forever begin
    exp_t e;
    @(negedge clk);
    #1;
    if (run) begin
      if (expq.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL scoreboard_empty actual=0 required=1 at %0t", $time);
      end else begin
        e = expq.pop_front();
        chk("alu_valid", 64'(alu_valid), 64'(e.av));
        chk("bru_valid", 64'(bru_valid), 64'(e.bv));
        chk("disp_ready", 64'(disp_ready), 64'(e.dr));
        chk("occupancy", 64'(occupancy), 64'(e.occ));
        if (e.av)
          chk("alu_payload", 64'({alu_uopcode, alu_imm, alu_imm_type, alu_rs1, alu_rs2, alu_rd, alu_rob}), 64'(e.ap));
        if (e.bv)
          chk("bru_payload", 64'({bru_uopcode, bru_imm, bru_imm_type, bru_rs1, bru_rs2, bru_rd, bru_rob}), 64'(e.bp));
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "timeout");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_disp(micro_opcode_t op, imm_type_t it, logic [TAG_W-1:0] a, bit ar,
                          logic [TAG_W-1:0] b, bit br);
    disp_uopcode  = op;
    disp_imm_type = it;
    disp_rs1      = a;
    disp_rs1_rdy  = ar;
    disp_rs2      = b;
    disp_rs2_rdy  = br;
    disp_imm      = 20'($urandom);
    disp_rd       = TAG_W'($urandom);
    disp_rob      = ROB_W'($urandom);
  endtask

  task automatic disp(micro_opcode_t op, imm_type_t it, logic [TAG_W-1:0] a, bit ar,
                      logic [TAG_W-1:0] b, bit br);
    set_disp(op, it, a, ar, b, br);
    disp_valid = 1'b1;
    step();
    disp_valid = 1'b0;
  endtask

  initial begin
    rst = 1'b0; flush = 1'b0; disp_valid = 1'b0; wk_valid = 1'b0; wk_tag = '0;
    alu_ready = 1'b0; bru_ready = 1'b0;
    set_disp(UOP_ADDI, IMM_I, 6'd1, 1'b1, 6'd2, 1'b1);
    step();
    step();
    run = 1'b1;
    step();
    rst = 1'b1;

    // addi with ready sources issues the cycle after dispatch
    alu_ready = 1'b1; bru_ready = 1'b1;
    disp(UOP_ADDI, IMM_I, 6'd1, 1'b1, 6'd2, 1'b1);
    repeat (2) step();

    // younger ready sub bypasses older add waiting on tag 5
    alu_ready = 1'b0;
    disp(UOP_ADD, IMM_I, 6'd5, 1'b0, 6'd0, 1'b0);
    disp(UOP_SUB, IMM_I, 6'd3, 1'b1, 6'd4, 1'b1);
    alu_ready = 1'b1;
    repeat (3) step();
    wk_valid = 1'b1; wk_tag = 6'd5;
    step();
    wk_valid = 1'b0;
    repeat (2) step();

    // branch and ALU op fire together
    alu_ready = 1'b0; bru_ready = 1'b0;
    disp(UOP_BEQ, IMM_B, 6'd1, 1'b1, 6'd2, 1'b1);
    disp(UOP_XORI, IMM_I, 6'd3, 1'b1, 6'd0, 1'b1);
    alu_ready = 1'b1; bru_ready = 1'b1;
    repeat (2) step();

    // fill to DEPTH, then one removal re-opens dispatch a cycle later
    alu_ready = 1'b0;
    repeat (DEPTH + 1) disp(UOP_ADDI, IMM_I, 6'd1, 1'b1, 6'd2, 1'b1);
    set_disp(UOP_ORI, IMM_I, 6'd1, 1'b1, 6'd1, 1'b1);
    disp_valid = 1'b1;
    alu_ready = 1'b1;
    step();
    alu_ready = 1'b0;
    step();
    disp_valid = 1'b0;
    alu_ready = 1'b1;
    repeat (DEPTH + 2) step();

    // flush with a dispatch in the same cycle
    alu_ready = 1'b0; bru_ready = 1'b0;
    disp(UOP_JAL, IMM_J, 6'd0, 1'b1, 6'd0, 1'b1);
    repeat (4) disp(UOP_ANDI, IMM_I, 6'd7, 1'b1, 6'd0, 1'b1);
    set_disp(UOP_LUI, IMM_U, 6'd0, 1'b1, 6'd0, 1'b1);
    disp_valid = 1'b1; flush = 1'b1;
    step();
    disp_valid = 1'b0; flush = 1'b0;
    alu_ready = 1'b1; bru_ready = 1'b1;
    repeat (2) step();

    // reset mid-stream, then a fresh dispatch
    alu_ready = 1'b0; bru_ready = 1'b0;
    repeat (3) disp(UOP_SLLI, IMM_I, 6'd2, 1'b1, 6'd0, 1'b1);
    rst = 1'b0;
    step();
    rst = 1'b1;
    disp(UOP_ORI, IMM_I, 6'd9, 1'b1, 6'd0, 1'b1);
    alu_ready = 1'b1;
    repeat (2) step();

    // randomized traffic with phased back-pressure
    for (int c = 0; c < 3000; c++) begin
      int ph;
      ph = (c / 500) % 3;
      set_disp(micro_opcode_t'($urandom_range(0, 28)), imm_type_t'($urandom_range(0, 4)),
               TAG_W'($urandom_range(0, 7)), 1'($urandom_range(0, 1)),
               TAG_W'($urandom_range(0, 7)), 1'($urandom_range(0, 1)));
      disp_valid = $urandom_range(0, 9) < 6;
      wk_valid   = $urandom_range(0, 9) < 4;
      wk_tag     = TAG_W'($urandom_range(0, 7));
      alu_ready  = $urandom_range(0, 9) < ph * 4 + 1;
      bru_ready  = $urandom_range(0, 9) < (2 - ph) * 4 + 1;
      flush      = $urandom_range(0, 99) == 0;
      rst        = !($urandom_range(0, 299) == 0);
      step();
    end

    disp_valid = 1'b0; flush = 1'b0; rst = 1'b1;
    alu_ready = 1'b1; bru_ready = 1'b1;
    repeat (DEPTH) begin
      wk_valid = 1'b1;
      wk_tag   = TAG_W'($urandom_range(1, 7));
      step();
    end
    wk_valid = 1'b0;
    repeat (10) step();
    run = 1'b0;
    step();
    chk("scoreboard_drained", 64'(expq.size()), 64'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/exe_issue_sched.md
# exe_issue_sched

Issue scheduler for the execute stage: a collapsing, age-ordered issue queue that accepts renamed micro-ops from dispatch, wakes source operands on result broadcasts, and selects the oldest ready micro-op for each of the two execute ports (ALU, BRU). The ALU and BRU decoders sit downstream of this block. The scheduler owns sharing of those two units among all in-flight micro-ops, and their flush on redirect.

## Interface
- `DEPTH`, 8: queue entries (power of two, 4..16)
- `TAG_W`, 6: physical-register tag width
- `ROB_W`, 5: ROB index width
- `clk` in 1: sole clock
- `rst` in 1: synchronous, active-low reset
- `flush` in 1: redirect; drops every entry
- `disp_valid` in 1: dispatch offers a micro-op
- `disp_ready` out 1: queue can accept
- `disp_uopcode` in `uopc::micro_opcode_t`: micro-opcode
- `disp_imm` in 20: packed immediate
- `disp_imm_type` in `immt::imm_type_t`: immediate format
- `disp_rs1`, `disp_rs2` in TAG_W each: source tags
- `disp_rs1_rdy`, `disp_rs2_rdy` in 1 each: source already available
- `disp_rd` in TAG_W: destination tag
- `disp_rob` in ROB_W: ROB index
- `wk_valid` in 1, `wk_tag` in TAG_W: result broadcast
- `alu_valid` out 1, `alu_ready` in 1: ALU issue handshake
- `bru_valid` out 1, `bru_ready` in 1: BRU issue handshake
- `alu_*`, `bru_*` out: issued uopcode, imm, imm_type, rs1, rs2, rd, rob (same widths as dispatch)
- `occupancy` out $clog2(DEPTH)+1: valid entry count

## Operation
- Class: `auipc, jal, jalr, beq, bne, blt, bge, bltu, bgeu` → BRU. All other uopcodes → ALU, including `lui`. Memory uops are never presented here.
- Queue slot 0 is oldest. Valid entries are always contiguous from slot 0.
- Entry fields: uop payload, `r1`, `r2` ready bits.
- Wakeup: on `wk_valid`, every valid entry sets `r1` if `rs1 == wk_tag` and sets `r2` if `rs2 == wk_tag`.
- Wakeup at dispatch: an accepted micro-op also sets a ready bit if its tag matches `wk_tag` that same cycle.
- Tag 0 is always ready.
- Select, per port: the lowest-index valid entry of that class with `r1 & r2` set. `*_valid` is driven combinationally from queue state, and the payload comes from that entry.
- Fire = `valid & ready`. Fired entries are removed at the clock edge. Remaining entries shift down to stay contiguous, keeping their order.
- Simultaneous events in one cycle are all applied at the edge: up to 2 removals, 1 append, and wakeup on every surviving entry.
- The appended entry lands at index `occupancy − fired_count`.
- `disp_ready = rst && !flush && occupancy < DEPTH`. It uses registered occupancy and does not credit same-cycle fires.
- Flush: at the edge, all entries are invalidated and `occupancy` becomes 0. A dispatch offered in the flush cycle is dropped. `alu_valid` and `bru_valid` are forced 0 in the flush cycle.

## Timing
- Reset, `rst` low at edge: `occupancy`=0, all entries invalid. During reset, `alu_valid`=`bru_valid`=0 and `disp_ready`=0.
- Reset mid-operation discards all contents, same as a flush.
- Minimum latency: a micro-op accepted in cycle N with both sources ready is selectable in cycle N+1.
- Wakeup-to-select: a broadcast in cycle N makes the entry selectable in N+1 by default (see Configuration).
- Full: with `occupancy`=DEPTH, `disp_ready`=0 even if a fire occurs that cycle. It rises in the cycle after the removal.
- Back-pressure: while `*_ready`=0, the selected entry stays selected. Its payload stays stable unless an older entry of the same class becomes ready.
- Holds on cleared `*_valid`: `*_valid` deasserts only on fire, flush or reset.
- The `occupancy` update is `occupancy + accept − fires`, with no wrap. Overflow is impossible by construction. Underflow is asserted never to occur.

## Configuration
- `EXE_WAKEUP_BYPASS_EN` defined: select uses ready bits OR'ed with the same-cycle `wk_tag` match. A broadcast in cycle N allows issue in cycle N; this applies to stored entries only, not to same-cycle dispatch.
- Undefined: select uses registered ready bits only, so issue occurs in N+1.

## Test plan
- Reset, then dispatch `addi` with both sources ready in cycle 1 → `alu_valid`=1 in cycle 2 with the `addi` payload. After the fire, `occupancy`=0 and `bru_valid` stays 0.
- Dispatch `add` (rs1 tag 5 not ready), then `sub` (ready) → `sub` issues first. Broadcast `wk_tag`=5 in cycle K → `add` issues in K+1. With `EXE_WAKEUP_BYPASS_EN`, `add` issues in K.
- Dispatch `beq` then `xori`, both ready, with `alu_ready`=`bru_ready`=1 → both fire in the same cycle. `occupancy` goes 2→0.
- Fill 8 entries with `alu_ready`=0 → `disp_ready`=0. Set `alu_ready`=1 for one cycle → slot 0 is removed, slot 1 becomes the new oldest, and `disp_ready`=1 the next cycle.
- With 5 entries, assert `flush` together with `disp_valid` → next cycle `occupancy`=0, the dispatched uop is absent, and both `*_valid`=0.
- Drive `rst`=0 mid-stream with 3 entries → all outputs reach their reset values, and the first post-reset dispatch issues with the correct payload.
